// File: rtl/dual_port_memory_pkg.sv
// Shared state encoding, collision-mode constants and byte-mask helper
// for the pipelined dual-port memory.
package dual_port_memory_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int COLL_READ_FIRST  = 0;
  localparam int COLL_WRITE_FIRST = 1;

  // Widest supported word is MAX_BYTES*8 bits; callers cast to their width.
  localparam int unsigned MAX_BYTES = 128;

  function automatic logic [MAX_BYTES*8-1:0] byte_en_to_mask(input logic [MAX_BYTES-1:0] be);
    logic [MAX_BYTES*8-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      mask[i*8 +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/dual_port_memory_pipe_rd_pipe.sv
// Read return pipeline: stage 0 captures the array read, then READ_LATENCY-1
// further stages carry {data, valid, err}. Data holds between valid beats.
module dpram_rd_pipe #(
  parameter int WIDTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_err,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_err
);

  logic [WIDTH-1:0]   data_q [LATENCY];
  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      err_q[0]   <= in_err;
      if (in_valid) begin
        data_q[0] <= in_data;
      end
      // Data only advances behind a valid beat so the last stage holds its value.
      for (int unsigned i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign out_data  = data_q[LATENCY-1];
  assign out_valid = valid_q[LATENCY-1];
  assign out_err   = err_q[LATENCY-1];

endmodule

// File: rtl/dual_port_memory_pipe.sv
// Single-clock 1W/1R memory with byte enables, post-reset clear sweep,
// selectable collision semantics and illegal-access error pulses.
module dual_port_memory_pipe
  import dual_port_memory_pkg::*;
#(
  parameter int RAM_WIDTH      = 64,
  parameter int RAM_DEPTH      = 1024,
  parameter int ADDR_SIZE      = 10,
  parameter int READ_LATENCY   = 1,
  parameter int COLLISION_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [RAM_WIDTH-1:0]   data_in,
  input  logic [RAM_WIDTH/8-1:0] wr_byte_en,
  input  logic [ADDR_SIZE-1:0]   wr_address,
  input  logic                   write,
  input  logic                   mem_wr_en,
  input  logic [ADDR_SIZE-1:0]   rd_address,
  input  logic                   read,
  input  logic                   mem_rd_en,
  output logic [RAM_WIDTH-1:0]   data_out,
  output logic                   data_valid,
  output logic                   init_done,
  output logic                   wr_err,
  output logic                   rd_err
);

  localparam int unsigned NB    = RAM_WIDTH / 8;
  localparam int          IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_SIZE:0] DEPTH_LIM = (ADDR_SIZE+1)'(RAM_DEPTH);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(RAM_DEPTH - 1);

  state_e           state, state_nxt;
  logic [IDX_W-1:0] clr_idx, clr_idx_nxt;
  logic             clr_we;
  logic             ready;

  logic             wr_req, wr_in_range, wr_ok;
  logic             rd_req, rd_in_range, rd_ok;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [RAM_WIDTH-1:0] wr_mask, merged, rd_word, rd_data;

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  // Clear sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    clr_we      = 1'b0;
    unique case (state)
      ST_INIT: begin
        clr_we      = 1'b1;
        clr_idx_nxt = clr_idx + IDX_W'(1);
        if (clr_idx == LAST_IDX) begin
          state_nxt   = ST_READY;
          clr_idx_nxt = '0;
        end
      end
      ST_READY: state_nxt = ST_READY;
      default:  state_nxt = ST_INIT;
    endcase
  end

  assign ready     = (state == ST_READY);
  assign init_done = ready;

  // Request qualification
  assign wr_req      = write && mem_wr_en;
  assign rd_req      = read && mem_rd_en;
  assign wr_in_range = {1'b0, wr_address} < DEPTH_LIM;
  assign rd_in_range = {1'b0, rd_address} < DEPTH_LIM;
  assign wr_ok       = wr_req && ready && wr_in_range;
  assign rd_ok       = rd_req && ready && rd_in_range;
  assign wr_idx      = wr_address[IDX_W-1:0];
  assign rd_idx      = rd_address[IDX_W-1:0];
  assign wr_mask     = RAM_WIDTH'(byte_en_to_mask(MAX_BYTES'(wr_byte_en)));

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (wr_ok) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (wr_byte_en[b]) begin
          mem[wr_idx][b*8 +: 8] <= data_in[b*8 +: 8];
        end
      end
    end
  end

  // Write-first bypasses the same-edge write around the array read.
  always_comb begin
    merged  = (mem[rd_idx] & ~wr_mask) | (data_in & wr_mask);
    rd_word = mem[rd_idx];
    if (COLLISION_MODE == COLL_WRITE_FIRST && wr_ok && rd_ok && (wr_idx == rd_idx)) begin
      rd_word = merged;
    end
  end

  assign rd_data = rd_ok ? rd_word : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_req && !wr_ok;
    end
  end

  dpram_rd_pipe #(
    .WIDTH   (RAM_WIDTH),
    .LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (rd_data),
    .in_valid  (rd_req),
    .in_err    (rd_req && !rd_ok),
    .out_data  (data_out),
    .out_valid (data_valid),
    .out_err   (rd_err)
  );

endmodule
